// File: rtl/dlfloat_operand_loader.sv
`default_nettype none
// ============================================================================
// Module   : dlfloat_operand_loader
// Brief    : Assembles a byte stream into DLFloat A/B operand pairs, tags each
//            pair with batch first/last flags and queues them for a MAC.
// Revision : 1.0 - initial release
// ============================================================================
module dlfloat_operand_loader #(
    parameter int FIFO_DEPTH = 2,
    parameter int LEN_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    input  logic [LEN_W-1:0] batch_len,
    input  logic             abort,
    output logic [15:0]      op_a,
    output logic [15:0]      op_b,
    output logic             op_valid,
    input  logic             op_ready,
    output logic             op_first,
    output logic             op_last
);

    localparam int c_PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int c_ENTRY_W = 34;

    typedef enum logic [1:0] {
        S_A_LO = 2'd0,
        S_A_HI = 2'd1,
        S_B_LO = 2'd2,
        S_B_HI = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [15:0]          r_a;
    logic [7:0]           r_b_lo;
    logic [LEN_W-1:0]     r_idx;
    logic [LEN_W-1:0]     r_len;
    logic [c_ENTRY_W-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr;
    logic [c_PTR_W-1:0]   r_rd;
    logic [c_CNT_W-1:0]   r_count;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_byte_xfer;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_first;
    logic                 w_last;
    logic [c_ENTRY_W-1:0] w_head;

    assign w_full      = (r_count == c_CNT_W'(FIFO_DEPTH));
    assign w_empty     = (r_count == '0);
    assign byte_ready  = ~rst & ~abort & ~w_full;
    assign w_byte_xfer = byte_valid & byte_ready;
    assign w_push      = w_byte_xfer & (r_state == S_B_HI);
    assign op_valid    = ~rst & ~w_empty;
    assign w_pop       = op_valid & op_ready;

    // A latched length of 0 wraps to all-ones here, i.e. a 2^LEN_W batch.
    assign w_first = (r_idx == '0);
    assign w_last  = (r_idx == (r_len - LEN_W'(1)));

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_A_LO;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = S_A_LO;
        end else if (w_byte_xfer) begin
            case (r_state)
                S_A_LO:  w_state_nxt = S_A_HI;
                S_A_HI:  w_state_nxt = S_B_LO;
                S_B_LO:  w_state_nxt = S_B_HI;
                default: w_state_nxt = S_A_LO;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_b_lo <= '0;
            r_idx  <= '0;
            r_len  <= '0;
        end else if (abort) begin
            r_idx  <= '0;
        end else if (w_byte_xfer) begin
            case (r_state)
                S_A_LO: begin
                    r_a[7:0] <= byte_in;
                    if (r_idx == '0) r_len <= batch_len;
                end
                S_A_HI:  r_a[15:8] <= byte_in;
                S_B_LO:  r_b_lo    <= byte_in;
                default: r_idx     <= w_last ? '0 : r_idx + LEN_W'(1);
            endcase
        end
    end

    // Storage carries no reset; outputs are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= {r_a, byte_in, r_b_lo, w_first, w_last};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= (r_wr == c_PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wr + c_PTR_W'(1);
            if (w_pop)  r_rd <= (r_rd == c_PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rd + c_PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head   = r_mem[r_rd];
    assign op_a     = op_valid ? w_head[33:18] : 16'h0000;
    assign op_b     = op_valid ? w_head[17:2]  : 16'h0000;
    assign op_first = op_valid & w_head[1];
    assign op_last  = op_valid & w_head[0];

endmodule
`default_nettype wire

// File: tb/tb_dlfloat_operand_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_dlfloat_operand_loader
// Brief    : Self-checking bench; a queue-based pair model predicts every output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dlfloat_operand_loader;

    localparam int DEPTH = 2;
    localparam int LW    = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    byte_in;
    logic          byte_valid;
    logic          byte_ready;
    logic [LW-1:0] batch_len;
    logic          abort;
    logic [15:0]   op_a;
    logic [15:0]   op_b;
    logic          op_valid;
    logic          op_ready;
    logic          op_first;
    logic          op_last;

    always #5 clk = ~clk;

    dlfloat_operand_loader #(.FIFO_DEPTH(DEPTH), .LEN_W(LW)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .batch_len  (batch_len),
        .abort      (abort),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_first   (op_first),
        .op_last    (op_last)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        f;
        logic        l;
    } pair_t;

    // Reference model: queued pairs, bytes collected so far, position in batch.
    pair_t      m_q[$];
    logic [7:0] m_part[3];
    int         m_nb   = 0;
    int         m_k    = 0;
    int         m_blen = 1 << LW;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic bv, input logic [7:0] b, input logic ab,
                        input logic rdy, input logic r);
        logic  exp_ready;
        logic  exp_valid;
        pair_t p;
        byte_valid = bv;
        byte_in    = b;
        abort      = ab;
        op_ready   = rdy;
        rst        = r;
        @(negedge clk);
        exp_ready = !r && !ab && (m_q.size() < DEPTH);
        exp_valid = !r && (m_q.size() > 0);
        check("byte_ready", byte_ready, exp_ready);
        check("op_valid",   op_valid,   exp_valid);
        check("op_a",     op_a,     exp_valid ? m_q[0].a : 16'h0);
        check("op_b",     op_b,     exp_valid ? m_q[0].b : 16'h0);
        check("op_first", op_first, exp_valid ? m_q[0].f : 1'b0);
        check("op_last",  op_last,  exp_valid ? m_q[0].l : 1'b0);
        if (r) begin
            m_q.delete();
            m_nb = 0;
            m_k  = 0;
        end else begin
            if (exp_valid && rdy) void'(m_q.pop_front());
            if (ab) begin
                m_nb = 0;
                m_k  = 0;
            end else if (bv && exp_ready) begin
                if (m_nb == 0 && m_k == 0)
                    m_blen = (batch_len == 0) ? (1 << LW) : int'(batch_len);
                if (m_nb < 3) begin
                    m_part[m_nb] = b;
                    m_nb++;
                end else begin
                    p.a  = {m_part[1], m_part[0]};
                    p.b  = {b, m_part[2]};
                    p.f  = (m_k == 0);
                    p.l  = (m_k == m_blen - 1);
                    m_k  = p.l ? 0 : m_k + 1;
                    m_nb = 0;
                    m_q.push_back(p);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] rb;
        int         rdy_pct;
        rst        = 1'b1;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        abort      = 1'b0;
        op_ready   = 1'b0;
        batch_len  = 8'd1;
        @(posedge clk);
        #1;
        repeat (3) step(1'b1, 8'hAA, 1'b0, 1'b1, 1'b1);

        // Single pair, batch length 1
        step(1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'h3E, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'h3E, 1'b0, 1'b1, 1'b0);
        check("single_valid", op_valid, 1'b1);
        check("single_a",     op_a,     16'h3E00);
        check("single_b",     op_b,     16'h3E00);
        check("single_first", op_first, 1'b1);
        check("single_last",  op_last,  1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Batch of 3, followed by the start of the next batch
        batch_len = 8'd3;
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i * 17 + 3), 1'b0, 1'b1, 1'b0);
        repeat (2) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Backpressure with a full queue
        for (int i = 0; i < 12; i++) step(1'b1, 8'(i + 8'h40), 1'b0, 1'b0, 1'b0);
        check("bp_ready_low", byte_ready, 1'b0);
        repeat (2) step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        repeat (8) step(1'b1, 8'h66, 1'b0, 1'b1, 1'b0);
        repeat (4) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Abort mid-pair while a pair is queued
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h70 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h90 + i), 1'b0, 1'b0, 1'b0);
        repeat (4) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Reset mid-operation with two pairs queued
        for (int i = 0; i < 10; i++) step(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b0, 1'b1, 1'b1);
        check("rst_valid", op_valid, 1'b0);
        check("rst_a",     op_a,     16'h0);
        for (int i = 0; i < 8; i++) step(1'b1, 8'(8'hB0 + i), 1'b0, 1'b1, 1'b0);

        // Randomized traffic
        for (int blk = 0; blk < 20; blk++) begin
            case ($urandom_range(0, 4))
                0:       batch_len = 8'd1;
                1:       batch_len = 8'd2;
                2:       batch_len = 8'd3;
                3:       batch_len = 8'd5;
                default: batch_len = 8'($urandom_range(0, 255));
            endcase
            rdy_pct = $urandom_range(10, 100);
            for (int c = 0; c < 200; c++) begin
                rb = 8'($urandom);
                step($urandom_range(0, 9) < 7, rb, $urandom_range(0, 99) < 2,
                     $urandom_range(1, 100) <= rdy_pct, $urandom_range(0, 499) == 0);
            end
        end

        // Full 2^LEN_W batch selected by a zero length
        batch_len = 8'd0;
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        for (int c = 0; c < 1100; c++) begin
            rb = 8'($urandom);
            step(1'b1, rb, 1'b0, 1'b1, 1'b0);
        end
        repeat (4) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
